// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU command encodings,
// shifter type codes, NZCV bit positions and a rotate helper.
package exe_stage_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Rotating the doubled word avoids the undefined x << 32 corner at n = 0.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] w_dbl;
        w_dbl = {x, x} >> n;
        return w_dbl[31:0];
    endfunction

endpackage

// File: rtl/exe_stage_val2_generate.sv
// Operand-2 generator: rotated 8-bit immediate, 12-bit memory offset,
// or the shifted Rm register operand.
module val2_generate
    import exe_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_imm,
    input  logic              i_mem_access,
    input  logic [DATA_W-1:0] i_val_rm,
    input  logic [11:0]       i_shift_operand,
    output logic [DATA_W-1:0] o_val2
);

    logic [DATA_W-1:0] w_imm8;
    logic [4:0]        w_rot_amt;
    logic [4:0]        w_sh_amt;
    logic [1:0]        w_sh_type;

    assign w_imm8    = {{(DATA_W-8){1'b0}}, i_shift_operand[7:0]};
    assign w_rot_amt = {i_shift_operand[11:8], 1'b0};
    assign w_sh_amt  = i_shift_operand[11:7];
    assign w_sh_type = i_shift_operand[6:5];

    always_comb begin
        o_val2 = '0;
        if (i_imm) begin
            o_val2 = ror32(w_imm8, w_rot_amt);
        end else if (i_mem_access) begin
            o_val2 = {{(DATA_W-12){1'b0}}, i_shift_operand};
        end else begin
            case (w_sh_type)
                SH_LSL:  o_val2 = i_val_rm << w_sh_amt;
                SH_LSR:  o_val2 = i_val_rm >> w_sh_amt;
                SH_ASR:  o_val2 = $signed(i_val_rm) >>> w_sh_amt;
                default: o_val2 = ror32(i_val_rm, w_sh_amt);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU with NZCV flags, status register, branch target
// computation and the EX/MEM pipeline register.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter logic [3:0] STATUS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [DATA_W-1:0] PC_in,
    input  logic              wb_enable_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              B_in,
    input  logic              S_in,
    input  logic              imm_in,
    input  logic [3:0]        exec_cmd_in,
    input  logic [DATA_W-1:0] val_Rn_in,
    input  logic [DATA_W-1:0] val_Rm_in,
    input  logic [3:0]        Rd_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status_q,
    output logic              wb_enable_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] st_val_out,
    output logic [3:0]        Rd_out
);

    logic [DATA_W-1:0] w_val2;
    logic [DATA_W-1:0] w_res;
    logic [DATA_W:0]   w_sum;
    logic              w_c_in;
    logic              w_c;
    logic              w_v;
    logic [3:0]        w_status_next;

    logic [3:0]        r_status;
    logic              r_wb_enable;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_st_val;
    logic [3:0]        r_rd;

    val2_generate #(
        .DATA_W(DATA_W)
    ) u_val2 (
        .i_imm          (imm_in),
        .i_mem_access   (mem_read_in | mem_write_in),
        .i_val_rm       (val_Rm_in),
        .i_shift_operand(shift_operand_in),
        .o_val2         (w_val2)
    );

    assign w_c_in = r_status[FLAG_C];

    // SUB/SBC add the one's complement so bit 32 is directly NOT-borrow.
    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = r_status[FLAG_C];
        w_v   = r_status[FLAG_V];
        case (exec_cmd_in)
            EXE_MOV: w_res = w_val2;
            EXE_MVN: w_res = ~w_val2;
            EXE_ADD, EXE_ADC: begin
                w_sum = {1'b0, val_Rn_in} + {1'b0, w_val2}
                      + {{DATA_W{1'b0}}, (exec_cmd_in == EXE_ADC) & w_c_in};
                w_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (val_Rn_in[DATA_W-1] == w_val2[DATA_W-1])
                      & (w_res[DATA_W-1] != val_Rn_in[DATA_W-1]);
            end
            EXE_SUB, EXE_SBC: begin
                w_sum = {1'b0, val_Rn_in} + {1'b0, ~w_val2}
                      + {{DATA_W{1'b0}}, (exec_cmd_in == EXE_SUB) | w_c_in};
                w_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (val_Rn_in[DATA_W-1] != w_val2[DATA_W-1])
                      & (w_res[DATA_W-1] != val_Rn_in[DATA_W-1]);
            end
            EXE_AND: w_res = val_Rn_in & w_val2;
            EXE_ORR: w_res = val_Rn_in | w_val2;
            EXE_EOR: w_res = val_Rn_in ^ w_val2;
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_status_next         = r_status;
        w_status_next[FLAG_N] = w_res[DATA_W-1];
        w_status_next[FLAG_Z] = (w_res == '0);
        w_status_next[FLAG_C] = w_c;
        w_status_next[FLAG_V] = w_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= STATUS_RST;
        end else if (S_in && !freeze) begin
            r_status <= w_status_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_enable  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_result <= '0;
            r_st_val     <= '0;
            r_rd         <= '0;
        end else if (!freeze) begin
            r_wb_enable  <= wb_enable_in;
            r_mem_read   <= mem_read_in;
            r_mem_write  <= mem_write_in;
            r_alu_result <= w_res;
            r_st_val     <= val_Rm_in;
            r_rd         <= Rd_in;
        end
    end

    // Branch path is combinational so fetch can redirect in the same cycle.
    assign branch_taken = B_in;
    assign branch_addr  = PC_in + {{(DATA_W-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

    assign status_q       = r_status;
    assign wb_enable_out  = r_wb_enable;
    assign mem_read_out   = r_mem_read;
    assign mem_write_out  = r_mem_write;
    assign alu_result_out = r_alu_result;
    assign st_val_out     = r_st_val;
    assign Rd_out         = r_rd;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes expected EX/MEM state,
// a monitor pops and compares after the target clock edge.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [31:0] PC_in;
    logic        wb_enable_in, mem_read_in, mem_write_in, B_in, S_in, imm_in;
    logic [3:0]  exec_cmd_in;
    logic [31:0] val_Rn_in, val_Rm_in;
    logic [3:0]  Rd_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status_q;
    logic        wb_enable_out, mem_read_out, mem_write_out;
    logic [31:0] alu_result_out, st_val_out;
    logic [3:0]  Rd_out;

    exe_stage #(
        .DATA_W    (32),
        .STATUS_RST(4'b0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .PC_in           (PC_in),
        .wb_enable_in    (wb_enable_in),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .B_in            (B_in),
        .S_in            (S_in),
        .imm_in          (imm_in),
        .exec_cmd_in     (exec_cmd_in),
        .val_Rn_in       (val_Rn_in),
        .val_Rm_in       (val_Rm_in),
        .Rd_in           (Rd_in),
        .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .status_q        (status_q),
        .wb_enable_out   (wb_enable_out),
        .mem_read_out    (mem_read_out),
        .mem_write_out   (mem_write_out),
        .alu_result_out  (alu_result_out),
        .st_val_out      (st_val_out),
        .Rd_out          (Rd_out)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  rd;
        logic [3:0]  status;
        logic        wb;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out_zero(input string nm);
        chk({nm, ".alu"}, alu_result_out, 32'h0);
        chk({nm, ".st"}, st_val_out, 32'h0);
        chk({nm, ".rd"}, {28'h0, Rd_out}, 32'h0);
        chk({nm, ".ctl"}, {29'h0, wb_enable_out, mem_read_out, mem_write_out}, 32'h0);
        chk({nm, ".status"}, {28'h0, status_q}, 32'h0);
    endtask

    // Monitor: compares every entry whose target edge has already occurred.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                $display("[TB] %s: alu=%h st=%h rd=%0d wb/mr/mw=%b%b%b nzcv=%b",
                         e.name, alu_result_out, st_val_out, Rd_out,
                         wb_enable_out, mem_read_out, mem_write_out, status_q);
                chk({e.name, ".alu"}, alu_result_out, e.alu);
                chk({e.name, ".st"}, st_val_out, e.st);
                chk({e.name, ".rd"}, {28'h0, Rd_out}, {28'h0, e.rd});
                chk({e.name, ".status"}, {28'h0, status_q}, {28'h0, e.status});
                chk({e.name, ".ctl"}, {29'h0, wb_enable_out, mem_read_out, mem_write_out},
                    {29'h0, e.wb, e.mr, e.mw});
            end
        end
    end

    task automatic apply(input logic [3:0] cmd, input logic s, input logic imm,
                         input logic wb, input logic mr, input logic mw,
                         input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] so, input logic [3:0] rd, input logic frz);
        exec_cmd_in      = cmd;
        S_in             = s;
        imm_in           = imm;
        wb_enable_in     = wb;
        mem_read_in      = mr;
        mem_write_in     = mw;
        val_Rn_in        = rn;
        val_Rm_in        = rm;
        shift_operand_in = so;
        Rd_in            = rd;
        freeze           = frz;
        B_in             = 1'b0;
        PC_in            = 32'h0;
        signed_imm_24_in = 24'h0;
    endtask

    // A frozen cycle expects the previous EX/MEM contents to persist.
    task automatic push_step(input string nm, input logic frz,
                             input logic [31:0] exp_alu, input logic [3:0] exp_status);
        exp_t e;
        if (frz) begin
            e = last_exp;
        end else begin
            e.alu    = exp_alu;
            e.st     = val_Rm_in;
            e.rd     = Rd_in;
            e.status = exp_status;
            e.wb     = wb_enable_in;
            e.mr     = mem_read_in;
            e.mw     = mem_write_in;
            last_exp = e;
        end
        e.name = nm;
        e.cyc  = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string nm, input logic [3:0] cmd, input logic s, input logic imm,
                         input logic wb, input logic mr, input logic mw,
                         input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] so, input logic [3:0] rd, input logic frz,
                         input logic [31:0] exp_alu, input logic [3:0] exp_status);
        apply(cmd, s, imm, wb, mr, mw, rn, rm, so, rd, frz);
        push_step(nm, frz, exp_alu, exp_status);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        #1;
        chk("drain.queue_empty", q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        apply(4'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 12'h0, 4'h0, 0);

        // Asynchronous reset asserted mid-cycle
        #3 rst = 1'b1;
        #1 chk_out_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 chk_out_zero("reset_hold");
        rst = 1'b0;

        //    name     cmd  S imm wb mr mw  Rn            Rm            so      Rd frz  exp_alu       nzcv
        issue("add_s",  4'h2, 1, 1, 1, 0, 0, 32'h7FFFFFFF, 32'h0,        12'h001, 1, 0, 32'h80000000, 4'b1001);
        issue("sub_s",  4'h4, 1, 0, 1, 0, 0, 32'h5,        32'h5,        12'h000, 2, 0, 32'h0,        4'b0110);
        issue("sbc_s",  4'h5, 1, 0, 1, 0, 0, 32'h5,        32'h3,        12'h000, 2, 0, 32'h2,        4'b0010);
        issue("lsl4",   4'h1, 0, 0, 1, 0, 0, 32'h0,        32'h80000001, 12'h200, 4, 0, 32'h00000010, 4'b0010);
        issue("asr1",   4'h1, 0, 0, 1, 0, 0, 32'h0,        32'h80000001, 12'h0C0, 4, 0, 32'hC0000000, 4'b0010);
        issue("lsr31",  4'h1, 0, 0, 1, 0, 0, 32'h0,        32'h80000000, 12'hFA0, 4, 0, 32'h00000001, 4'b0010);
        issue("ror1",   4'h1, 0, 0, 1, 0, 0, 32'h0,        32'h00000003, 12'h0E0, 4, 0, 32'h80000001, 4'b0010);
        issue("imm_rot",4'h1, 0, 1, 1, 0, 0, 32'h0,        32'h0,        12'h4FF, 6, 0, 32'hFF000000, 4'b0010);
        issue("mvn_s",  4'h9, 1, 1, 1, 0, 0, 32'h0,        32'h0,        12'h000, 6, 0, 32'hFFFFFFFF, 4'b1010);
        issue("dflt_s", 4'hF, 1, 0, 1, 0, 0, 32'h1234,     32'h5678,     12'h000, 7, 0, 32'h0,        4'b0110);
        issue("adc_s",  4'h3, 1, 1, 1, 0, 0, 32'hFFFFFFFF, 32'h0,        12'h001, 8, 0, 32'h00000001, 4'b0010);
        issue("eor",    4'h8, 0, 0, 1, 0, 0, 32'hFF00FF00, 32'h0FF00FF0, 12'h000, 9, 0, 32'hF0F0F0F0, 4'b0010);
        issue("ldr",    4'h2, 0, 0, 1, 1, 0, 32'h1000,     32'h0,        12'hABC, 9, 0, 32'h00001ABC, 4'b0010);

        // Store, then three frozen cycles with changing inputs and S set
        issue("str",    4'h2, 0, 0, 0, 0, 1, 32'h100,      32'hDEADBEEF, 12'h004, 3, 0, 32'h00000104, 4'b0010);
        issue("frz1",   4'h4, 1, 0, 1, 0, 0, 32'h1,        32'h2,        12'h000, 7, 1, 32'h0,        4'b0000);
        issue("frz2",   4'h4, 1, 0, 1, 1, 0, 32'h1,        32'h2,        12'h010, 8, 1, 32'h0,        4'b0000);
        issue("frz3",   4'h4, 1, 0, 1, 0, 0, 32'h1,        32'h2,        12'h000, 9, 1, 32'h0,        4'b0000);
        issue("and_s",  4'h6, 1, 0, 1, 0, 0, 32'hF0,       32'h0F,       12'h000, 5, 0, 32'h0,        4'b0110);
        issue("bubble", 4'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        12'h000, 0, 0, 32'h0,        4'b0110);

        // Branch: combinational target, visible even while frozen
        apply(4'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 12'h000, 0, 1);
        B_in             = 1'b1;
        PC_in            = 32'h20;
        signed_imm_24_in = 24'hFFFFFE;
        #1;
        chk("branch_frz.taken", {31'h0, branch_taken}, 32'h1);
        chk("branch_frz.addr", branch_addr, 32'h18);
        freeze = 1'b0;
        #1;
        chk("branch.taken", {31'h0, branch_taken}, 32'h1);
        chk("branch.addr", branch_addr, 32'h18);
        $display("[TB] branch: taken=%b addr=%h", branch_taken, branch_addr);
        push_step("branch", 0, 32'h0, 4'b0110);
        drain();

        // Reset during a stall: rst wins, outputs clear before the next edge
        apply(4'h2, 1, 1, 1, 1, 0, 32'h7FFFFFFF, 32'h1, 12'h001, 4'hA, 1);
        #2 rst = 1'b1;
        #1 chk_out_zero("reset_stall");
        repeat (2) @(posedge clk);
        #1 chk_out_zero("reset_stall_hold");
        rst    = 1'b0;
        freeze = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
